// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the uart_tx_dev peripheral: register map, field positions, FSM encoding.
package uart_tx_dev_pkg;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_BUSY      = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_dev_fifo.sv
// Synchronous FIFO with registered full/empty/count; a push is accepted when not full or when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     push_ok_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_n;
  logic             do_pop;

  always_comb begin
    do_pop    = pop && !empty;
    push_ok_c = push && (!full || do_pop);
    count_n   = count;
    if (push_ok_c && !do_pop)      count_n = count + CW'(1);
    else if (!push_ok_c && do_pop) count_n = count - CW'(1);
  end

  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)    rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Bridge-attached 8N1 serial transmitter: register decode, byte FIFO, baud counter and frame FSM.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        TxWrite,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        txd,
  output logic        IRQ
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]        ctrl;
  logic [DIV_W-1:0]  divisor;
  logic              ovf;
  logic              irq;

  tx_state_e         state, state_n;
  logic [DIV_W-1:0]  cnt, cnt_n;
  logic [DIV_W-1:0]  nlat, nlat_n;
  logic [2:0]        idx, idx_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              txd_r, txd_n;
  logic              pop;

  logic              wr_ctrl, wr_div, wr_tx, wr_status;
  logic              push_ok;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              en, ie, busy, start_ok, bit_done;
  logic [DIV_W-1:0]  n_eff;
  logic [31:0]       status;
  logic              unused_bits;

  assign wr_ctrl   = TxWrite && (Addr[3:2] == REG_CTRL);
  assign wr_div    = TxWrite && (Addr[3:2] == REG_DIV);
  assign wr_tx     = TxWrite && (Addr[3:2] == REG_TXDATA);
  assign wr_status = TxWrite && (Addr[3:2] == REG_STATUS);

  assign en       = ctrl[CTRL_EN];
  assign ie       = ctrl[CTRL_IE];
  assign busy     = (state != S_IDLE);
  assign start_ok = en && !fifo_empty;
  assign n_eff    = (divisor == '0) ? DIV_W'(1) : divisor;
  assign bit_done = (cnt == nlat - DIV_W'(1));
  assign unused_bits = ^{Addr[31:4], Din[31:16]};

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_tx),
    .din       (Din[DATA_W-1:0]),
    .pop       (pop),
    .rd_data_c (fifo_head),
    .push_ok_c (push_ok),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl    <= '0;
      divisor <= DIV_RESET;
      ovf     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= Din[1:0];
      if (wr_div)  divisor <= Din[DIV_W-1:0];
      if (wr_status)             ovf <= 1'b0;
      else if (wr_tx && !push_ok) ovf <= 1'b1;
      irq <= ie && en && fifo_empty && !busy;
    end
  end

  // Bit period is latched into nlat at each frame start so mid-frame divisor writes wait.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + DIV_W'(1);
    nlat_n  = nlat;
    idx_n   = idx;
    sh_n    = sh;
    txd_n   = txd_r;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (start_ok) begin
          pop     = 1'b1;
          state_n = S_START;
          sh_n    = fifo_head;
          txd_n   = 1'b0;
          nlat_n  = n_eff;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_n = S_DATA;
          cnt_n   = '0;
          idx_n   = '0;
          txd_n   = sh[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n = S_STOP;
            txd_n   = 1'b1;
          end else begin
            sh_n  = {1'b0, sh[DATA_W-1:1]};
            txd_n = sh[1];
            idx_n = idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_n = '0;
          idx_n = '0;
          if (start_ok) begin
            pop     = 1'b1;
            state_n = S_START;
            sh_n    = fifo_head;
            txd_n   = 1'b0;
            nlat_n  = n_eff;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      nlat  <= DIV_W'(1);
      idx   <= '0;
      sh    <= '0;
      txd_r <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      nlat  <= nlat_n;
      idx   <= idx_n;
      sh    <= sh_n;
      txd_r <= txd_n;
    end
  end

  assign txd = txd_r;
  assign IRQ = irq;

  always_comb begin
    status = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf;
    status[ST_COUNT_LSB +: 4] = 4'(fifo_count);
    Dout = '0;
    case (Addr[3:2])
      REG_CTRL:   Dout = 32'(ctrl);
      REG_DIV:    Dout = 32'(divisor);
      REG_STATUS: Dout = status;
      default:    Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: register table, frame shape, FIFO overflow, IRQ, divisor and reset corners.
module tb_uart_tx_dev;
  import uart_tx_dev_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        TxWrite;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        txd;
  logic        IRQ;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [1:0]  a;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  uart_tx_dev #(.DEPTH(4), .DIV_RESET(16'd434)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .TxWrite(TxWrite),
    .Din(Din), .Dout(Dout), .txd(txd), .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Drive a one-cycle write; returns at the negedge after the capturing posedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'hABCDEF1, a};
    Din = d;
    TxWrite = 1'b1;
    @(negedge clk);
    TxWrite = 1'b0;
    Din = '0;
    Addr = {28'h0, REG_STATUS};
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = {28'h5555555, a};
    #1 v = Dout;
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Samples one 10-bit frame of n clocks per bit, checking each bit is held steady.
  task automatic cap_frame(input int n, input bit use_busy, output logic [9:0] bits,
                           output bit stable, output int busy_n);
    stable = 1'b1;
    busy_n = 0;
    bits = '0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < n; j++) begin
        @(negedge clk);
        if (j == 0) bits[k] = txd;
        else if (txd !== bits[k]) stable = 1'b0;
        if (use_busy && Dout[ST_BUSY]) busy_n++;
      end
    end
  endtask

  vec_t        vt[9];
  logic [31:0] v;
  logic [9:0]  fb;
  bit          st;
  int          bn;
  logic        acc;
  logic [7:0]  exp_b [4];

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    TxWrite = 1'b0;
    Addr = '0;
    Din = '0;

    vt[0] = '{REG_CTRL,   1'b0, 32'h0,         32'h0};
    vt[1] = '{REG_DIV,    1'b0, 32'h0,         32'd434};
    vt[2] = '{REG_TXDATA, 1'b0, 32'h0,         32'h0};
    vt[3] = '{REG_STATUS, 1'b0, 32'h0,         32'h1};
    vt[4] = '{REG_CTRL,   1'b1, 32'hFFFF_FFFE, 32'h2};
    vt[5] = '{REG_DIV,    1'b1, 32'hDEAD_BEEF, 32'h0000_BEEF};
    vt[6] = '{REG_DIV,    1'b1, 32'h0,         32'h0};
    vt[7] = '{REG_STATUS, 1'b1, 32'hFFFF_FFFF, 32'h1};
    vt[8] = '{REG_CTRL,   1'b1, 32'h0,         32'h0};

    repeat (3) tick();
    chk("reset_txd", 32'(txd), 32'h1);
    chk("reset_irq", 32'(IRQ), 32'h0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      if (vt[i].w) wr(vt[i].a, vt[i].d);
      rd(vt[i].a, v);
      chk($sformatf("regvec%0d", i), v, vt[i].exp);
    end

    // Single frame, divisor 2
    wr(REG_DIV, 32'd2);
    wr(REG_CTRL, 32'd1);
    wr(REG_TXDATA, 32'hA5);
    Addr = {28'h0, REG_STATUS};
    cap_frame(2, 1'b1, fb, st, bn);
    chk("a5_frame", 32'(fb), 32'(frame_of(8'hA5)));
    chk("a5_stable", 32'(st), 32'h1);
    chk("a5_busy_clocks", 32'(bn), 32'd20);
    tick();
    rd(REG_STATUS, v);
    chk("a5_idle_status", v, 32'h01);
    chk("a5_idle_txd", 32'(txd), 32'h1);

    // Overflow then back-to-back frames
    wr(REG_CTRL, 32'd0);
    wr(REG_DIV, 32'd1);
    wr(REG_TXDATA, 32'h11);
    wr(REG_TXDATA, 32'h22);
    wr(REG_TXDATA, 32'h33);
    wr(REG_TXDATA, 32'h44);
    wr(REG_TXDATA, 32'h55);
    rd(REG_STATUS, v);
    chk("ovf_status", v, 32'h4A);
    wr(REG_STATUS, 32'h0);
    rd(REG_STATUS, v);
    chk("ovf_cleared", v, 32'h42);
    wr(REG_CTRL, 32'd1);
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int f = 0; f < 4; f++) begin
      cap_frame(1, 1'b0, fb, st, bn);
      chk($sformatf("b2b_frame%0d", f), 32'(fb), 32'(frame_of(exp_b[f])));
    end
    acc = 1'b1;
    repeat (12) begin
      tick();
      acc = acc & txd;
    end
    chk("b2b_no_fifth", 32'(acc), 32'h1);
    rd(REG_STATUS, v);
    chk("b2b_drained", v, 32'h01);

    // Interrupt behaviour
    wr(REG_CTRL, 32'd3);
    wr(REG_TXDATA, 32'h00);
    acc = 1'b0;
    repeat (10) begin
      tick();
      acc = acc | IRQ;
    end
    chk("irq_low_in_frame", 32'(acc), 32'h0);
    tick();
    chk("irq_lag", 32'(IRQ), 32'h0);
    tick();
    chk("irq_rise", 32'(IRQ), 32'h1);
    wr(REG_TXDATA, 32'h01);
    tick();
    chk("irq_push_clear", 32'(IRQ), 32'h0);
    repeat (12) tick();
    chk("irq_again", 32'(IRQ), 32'h1);
    wr(REG_CTRL, 32'd1);
    tick();
    chk("irq_ie_clear", 32'(IRQ), 32'h0);
    wr(REG_CTRL, 32'd3);
    tick();
    chk("irq_reenable", 32'(IRQ), 32'h1);
    wr(REG_CTRL, 32'd2);
    tick();
    chk("irq_en_clear", 32'(IRQ), 32'h0);

    // EN cleared during data bit 3
    wr(REG_CTRL, 32'd0);
    wr(REG_DIV, 32'd2);
    wr(REG_TXDATA, 32'h3C);
    wr(REG_TXDATA, 32'hC3);
    wr(REG_CTRL, 32'd1);
    repeat (9) tick();
    wr(REG_CTRL, 32'd0);
    repeat (10) tick();
    rd(REG_STATUS, v);
    chk("dis_still_busy", v, 32'h14);
    tick();
    rd(REG_STATUS, v);
    chk("dis_done", v, 32'h10);
    acc = 1'b1;
    repeat (20) begin
      tick();
      acc = acc & txd;
    end
    chk("dis_txd_idle", 32'(acc), 32'h1);
    rd(REG_STATUS, v);
    chk("dis_count_kept", v, 32'h10);

    // Divisor 0 behaves as one clock per bit
    wr(REG_DIV, 32'd0);
    wr(REG_CTRL, 32'd1);
    cap_frame(1, 1'b0, fb, st, bn);
    chk("div0_frame", 32'(fb), 32'(frame_of(8'hC3)));
    chk("div0_stable", 32'(st), 32'h1);

    // Divisor write mid-frame applies to the next frame only
    wr(REG_DIV, 32'd3);
    wr(REG_TXDATA, 32'h96);
    fork
      cap_frame(3, 1'b0, fb, st, bn);
      begin
        repeat (5) tick();
        wr(REG_DIV, 32'd1);
      end
    join
    chk("divmid_frame", 32'(fb), 32'(frame_of(8'h96)));
    chk("divmid_stable", 32'(st), 32'h1);
    wr(REG_TXDATA, 32'h5A);
    cap_frame(1, 1'b0, fb, st, bn);
    chk("divnext_frame", 32'(fb), 32'(frame_of(8'h5A)));
    chk("divnext_stable", 32'(st), 32'h1);

    // Push on the same edge as a pop with the FIFO full
    wr(REG_CTRL, 32'd0);
    wr(REG_TXDATA, 32'hA1);
    wr(REG_TXDATA, 32'hA2);
    wr(REG_TXDATA, 32'hA3);
    wr(REG_TXDATA, 32'hA4);
    rd(REG_STATUS, v);
    chk("pp_full", v, 32'h42);
    wr(REG_CTRL, 32'd1);
    wr(REG_TXDATA, 32'hA5);
    rd(REG_STATUS, v);
    chk("pp_status", v, 32'h46);
    repeat (9) tick();
    exp_b = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int f = 0; f < 4; f++) begin
      cap_frame(1, 1'b0, fb, st, bn);
      chk($sformatf("pp_frame%0d", f), 32'(fb), 32'(frame_of(exp_b[f])));
    end

    // Reset in the middle of a start bit
    wr(REG_CTRL, 32'd3);
    wr(REG_DIV, 32'd4);
    wr(REG_TXDATA, 32'h77);
    wr(REG_TXDATA, 32'h88);
    chk("prereset_txd", 32'(txd), 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("midreset_txd", 32'(txd), 32'h1);
    chk("midreset_irq", 32'(IRQ), 32'h0);
    tick();
    rd(REG_CTRL, v);
    chk("midreset_ctrl", v, 32'h0);
    rd(REG_DIV, v);
    chk("midreset_div", v, 32'd434);
    rd(REG_STATUS, v);
    chk("midreset_status", v, 32'h01);
    tick();
    reset = 1'b1;
    acc = 1'b1;
    repeat (10) begin
      tick();
      acc = acc & txd;
    end
    chk("postreset_txd", 32'(acc), 32'h1);
    rd(REG_STATUS, v);
    chk("postreset_status", v, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
